// File: rtl/dlsc_axi_rd_router.sv
// AXI read router: round-robin picks one master, decodes its AR address to a
// slave (or a local DECERR responder), and steers R beats back until last.
module dlsc_axi_rd_router #(
    parameter int MASTERS = 2,
    parameter int SLAVES  = 2,
    parameter int ADDR    = 32,
    parameter int DATA    = 32,
    parameter int LEN     = 4,
    parameter logic [SLAVES*ADDR-1:0] MASKS = '0,
    parameter logic [SLAVES*ADDR-1:0] BASES = '0
) (
    input  logic                    clk,
    input  logic                    rst,

    output logic [MASTERS-1:0]      in_ar_ready,
    input  logic [MASTERS-1:0]      in_ar_valid,
    input  logic [MASTERS*ADDR-1:0] in_ar_addr,
    input  logic [MASTERS*LEN-1:0]  in_ar_len,
    input  logic [MASTERS-1:0]      in_r_ready,
    output logic [MASTERS-1:0]      in_r_valid,
    output logic [MASTERS-1:0]      in_r_last,
    output logic [MASTERS*DATA-1:0] in_r_data,
    output logic [MASTERS*2-1:0]    in_r_resp,

    input  logic [SLAVES-1:0]       out_ar_ready,
    output logic [SLAVES-1:0]       out_ar_valid,
    output logic [ADDR-1:0]         out_ar_addr,
    output logic [LEN-1:0]          out_ar_len,
    output logic [SLAVES-1:0]       out_r_ready,
    input  logic [SLAVES-1:0]       out_r_valid,
    input  logic [SLAVES-1:0]       out_r_last,
    input  logic [SLAVES*DATA-1:0]  out_r_data,
    input  logic [SLAVES*2-1:0]     out_r_resp
);

    localparam int MW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
    localparam int SW = (SLAVES > 1) ? $clog2(SLAVES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    state_t          state;
    logic [MW-1:0]   grant;
    logic [MW-1:0]   ptr;
    logic [SW-1:0]   sel;
    logic [ADDR-1:0] addr_r;
    logic [LEN-1:0]  len_r;
    logic [LEN-1:0]  beat;
    logic            ar_done;

    logic            req_any;
    logic [MW-1:0]   req_idx;
    logic [ADDR-1:0] req_addr;
    logic [LEN-1:0]  req_len;
    logic            dec_hit;
    logic [SW-1:0]   dec_sel;
    logic [MW-1:0]   ptr_next;
    int              idx;

    // Scan downward so the first requester at or above ptr (wrapping) wins.
    always_comb begin
        req_any  = 1'b0;
        req_idx  = '0;
        req_addr = '0;
        req_len  = '0;
        idx      = 0;
        for (int k = MASTERS - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % MASTERS;
            if (in_ar_valid[idx]) begin
                req_any  = 1'b1;
                req_idx  = MW'(idx);
                req_addr = in_ar_addr[idx*ADDR +: ADDR];
                req_len  = in_ar_len[idx*LEN +: LEN];
            end
        end
    end

    // Downward scan again: on overlapping ranges the lowest slave index wins.
    always_comb begin
        dec_hit = 1'b0;
        dec_sel = '0;
        for (int i = SLAVES - 1; i >= 0; i--) begin
            if ((req_addr & ~MASKS[i*ADDR +: ADDR]) ==
                (BASES[i*ADDR +: ADDR] & ~MASKS[i*ADDR +: ADDR])) begin
                dec_hit = 1'b1;
                dec_sel = SW'(i);
            end
        end
    end

    assign ptr_next = (req_idx == MW'(MASTERS - 1)) ? '0 : req_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            grant   <= '0;
            ptr     <= '0;
            sel     <= '0;
            addr_r  <= '0;
            len_r   <= '0;
            beat    <= '0;
            ar_done <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_any) begin
                        grant   <= req_idx;
                        sel     <= dec_sel;
                        addr_r  <= req_addr;
                        len_r   <= req_len;
                        beat    <= '0;
                        ar_done <= 1'b0;
                        ptr     <= ptr_next;
                        state   <= dec_hit ? ST_ADDR : ST_ERR;
                    end
                end
                ST_ADDR: begin
                    if (out_ar_ready[sel]) state <= ST_DATA;
                end
                ST_DATA: begin
                    if (out_r_valid[sel] && in_r_ready[grant] && out_r_last[sel])
                        state <= ST_IDLE;
                end
                ST_ERR: begin
                    // First ERR cycle accepts the AR; afterwards emit len+1 DECERR beats.
                    if (!ar_done) begin
                        ar_done <= 1'b1;
                    end else if (in_r_ready[grant]) begin
                        if (beat == len_r) state <= ST_IDLE;
                        else               beat  <= beat + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign out_ar_addr = addr_r;
    assign out_ar_len  = len_r;

    always_comb begin
        in_ar_ready  = '0;
        in_r_valid   = '0;
        in_r_last    = '0;
        in_r_data    = '0;
        in_r_resp    = '0;
        out_ar_valid = '0;
        out_r_ready  = '0;
        case (state)
            ST_ADDR: begin
                out_ar_valid[sel] = 1'b1;
                in_ar_ready[grant] = out_ar_ready[sel];
            end
            ST_DATA: begin
                in_r_valid[grant]              = out_r_valid[sel];
                in_r_last[grant]               = out_r_last[sel];
                in_r_data[grant*DATA +: DATA]  = out_r_data[sel*DATA +: DATA];
                in_r_resp[grant*2 +: 2]        = out_r_resp[sel*2 +: 2];
                out_r_ready[sel]               = in_r_ready[grant];
            end
            ST_ERR: begin
                if (!ar_done) begin
                    in_ar_ready[grant] = 1'b1;
                end else begin
                    in_r_valid[grant]       = 1'b1;
                    in_r_resp[grant*2 +: 2] = 2'b11;
                    in_r_last[grant]        = (beat == len_r);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dlsc_axi_rd_router.sv
// Bench for dlsc_axi_rd_router: directed scenarios plus randomized traffic
// checked against an address-range / round-robin reference model.
module tb_dlsc_axi_rd_router;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  in_ar_ready;
    logic [1:0]  in_ar_valid;
    logic [63:0] in_ar_addr;
    logic [7:0]  in_ar_len;
    logic [1:0]  in_r_ready;
    logic [1:0]  in_r_valid;
    logic [1:0]  in_r_last;
    logic [63:0] in_r_data;
    logic [3:0]  in_r_resp;
    logic [1:0]  out_ar_ready;
    logic [1:0]  out_ar_valid;
    logic [31:0] out_ar_addr;
    logic [3:0]  out_ar_len;
    logic [1:0]  out_r_ready;
    logic [1:0]  out_r_valid;
    logic [1:0]  out_r_last;
    logic [63:0] out_r_data;
    logic [3:0]  out_r_resp;

    int total = 0;
    int bad   = 0;
    int rr    = 0;
    logic [33:0] exp_q[$];

    dlsc_axi_rd_router #(
        .MASTERS(2), .SLAVES(2), .ADDR(32), .DATA(32), .LEN(4),
        .MASKS({32'h0000FFFF, 32'h0000FFFF}),
        .BASES({32'h00010000, 32'h00000000})
    ) dut (
        .clk(clk), .rst(rst),
        .in_ar_ready(in_ar_ready), .in_ar_valid(in_ar_valid),
        .in_ar_addr(in_ar_addr), .in_ar_len(in_ar_len),
        .in_r_ready(in_r_ready), .in_r_valid(in_r_valid),
        .in_r_last(in_r_last), .in_r_data(in_r_data), .in_r_resp(in_r_resp),
        .out_ar_ready(out_ar_ready), .out_ar_valid(out_ar_valid),
        .out_ar_addr(out_ar_addr), .out_ar_len(out_ar_len),
        .out_r_ready(out_r_ready), .out_r_valid(out_r_valid),
        .out_r_last(out_r_last), .out_r_data(out_r_data), .out_r_resp(out_r_resp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave 0 owns 0x0000_xxxx, slave 1 owns 0x0001_xxxx, everything else is unmapped.
    function automatic int ref_slave(input logic [31:0] a);
        if (a < 32'h0001_0000) return 0;
        if (a < 32'h0002_0000) return 1;
        return -1;
    endfunction

    function automatic int ref_grant(input logic [1:0] req);
        for (int k = 0; k < 2; k++) begin
            if (req[(rr + k) % 2]) return (rr + k) % 2;
        end
        return 0;
    endfunction

    task automatic clear_inputs();
        in_ar_valid  = '0;
        in_r_ready   = '0;
        out_ar_ready = '0;
        out_r_valid  = '0;
        out_r_last   = '0;
        out_r_data   = '0;
        out_r_resp   = '0;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_in_ar_ready"}, 64'(in_ar_ready), 64'd0);
        chk({tag, "_in_r_valid"},  64'(in_r_valid),  64'd0);
        chk({tag, "_in_r_last"},   64'(in_r_last),   64'd0);
        chk({tag, "_in_r_data"},   in_r_data,        64'd0);
        chk({tag, "_in_r_resp"},   64'(in_r_resp),   64'd0);
        chk({tag, "_out_ar_valid"}, 64'(out_ar_valid), 64'd0);
        chk({tag, "_out_r_ready"}, 64'(out_r_ready), 64'd0);
    endtask

    // rmode: 0 always ready, 1 ready toggles 1,0,..., 2 random ready/valid, 3 ready low for 3 cycles
    task automatic do_txn(input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
                          input logic [3:0] l0, input logic [3:0] l1, input int stall, input int rmode);
        int m, s, len, b, cyc;
        logic [31:0] a;
        logic vld, rdy, last;
        logic [33:0] e;
        logic [63:0] od;
        logic [3:0]  orsp;
        logic [1:0]  olst, ovld;
        m   = ref_grant(req);
        a   = (m == 1) ? a1 : a0;
        len = (m == 1) ? int'(l1) : int'(l0);
        s   = ref_slave(a);
        in_ar_valid = req;
        in_ar_addr  = {a1, a0};
        in_ar_len   = {l1, l0};
        settle();
        chk("idle_ar_ready", 64'(in_ar_ready), 64'd0);
        chk("idle_ar_valid", 64'(out_ar_valid), 64'd0);
        tick();
        rr = (m + 1) % 2;
        if (s >= 0) begin
            for (int i = 0; i < stall; i++) begin
                out_ar_ready = 2'(1 << (1 - s));
                settle();
                chk("stall_ar_valid", 64'(out_ar_valid), 64'(1 << s));
                chk("stall_ar_addr", 64'(out_ar_addr), 64'(a));
                chk("stall_ar_len", 64'(out_ar_len), 64'(len));
                chk("stall_in_ar_ready", 64'(in_ar_ready), 64'd0);
                tick();
            end
            out_ar_ready = 2'b11;
            settle();
            chk("ar_valid", 64'(out_ar_valid), 64'(1 << s));
            chk("ar_addr", 64'(out_ar_addr), 64'(a));
            chk("ar_len", 64'(out_ar_len), 64'(len));
            chk("ar_ready_grant", 64'(in_ar_ready), 64'(1 << m));
            tick();
        end else begin
            settle();
            chk("err_ar_ready", 64'(in_ar_ready), 64'(1 << m));
            chk("err_no_slave", 64'(out_ar_valid), 64'd0);
            chk("err_no_rvalid", 64'(in_r_valid), 64'd0);
            tick();
        end
        in_ar_valid  = '0;
        out_ar_ready = '0;
        for (int i = 0; i <= len; i++) begin
            if (s >= 0) exp_q.push_back({2'($urandom_range(0, 3)), 32'($urandom)});
            else        exp_q.push_back({2'b11, 32'h0});
        end
        b = 0;
        cyc = 0;
        while (b <= len && cyc < 200) begin
            e    = exp_q[0];
            last = (b == len);
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                2:       rdy = 1'($urandom_range(0, 1));
                default: rdy = (cyc >= 3);
            endcase
            vld = (s < 0) ? 1'b1 : ((rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1);
            in_r_ready = 2'($urandom_range(0, 3));
            in_r_ready[m] = rdy;
            ovld = 2'($urandom_range(0, 3));
            olst = 2'($urandom_range(0, 3));
            orsp = 4'($urandom_range(0, 15));
            od   = {32'($urandom), 32'($urandom)};
            if (s >= 0) begin
                ovld[s] = vld;
                olst[s] = last;
                orsp[s*2 +: 2]  = e[33:32];
                od[s*32 +: 32]  = e[31:0];
            end
            out_r_valid = ovld;
            out_r_last  = olst;
            out_r_resp  = orsp;
            out_r_data  = od;
            settle();
            chk("r_valid", 64'(in_r_valid), vld ? 64'(1 << m) : 64'd0);
            chk("r_ready_slave", 64'(out_r_ready), (s >= 0 && rdy) ? 64'(1 << s) : 64'd0);
            chk("r_ar_quiet", 64'(out_ar_valid), 64'd0);
            if (vld) begin
                chk("r_data", in_r_data, 64'(e[31:0]) << (m * 32));
                chk("r_resp", 64'(in_r_resp), 64'(e[33:32]) << (m * 2));
                chk("r_last", 64'(in_r_last), last ? 64'(1 << m) : 64'd0);
            end
            tick();
            cyc++;
            if (vld && rdy) begin
                void'(exp_q.pop_front());
                b++;
            end
        end
        if (b <= len) chk("beat_timeout", 64'(b), 64'(len + 1));
        exp_q.delete();
        clear_inputs();
        settle();
        check_quiet("end_idle");
    endtask

    initial begin
        clear_inputs();
        in_ar_addr = '0;
        in_ar_len  = '0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        settle();
        check_quiet("reset");
        chk("reset_ar_addr", 64'(out_ar_addr), 64'd0);
        chk("reset_ar_len", 64'(out_ar_len), 64'd0);

        // master0, slave0, len 3, immediate AR ready
        do_txn(2'b01, 32'h0000_0040, 32'h0, 4'd3, 4'd0, 0, 0);
        // master1, slave1, len 0, AR stalled 5 cycles
        do_txn(2'b10, 32'h0, 32'h0001_0008, 4'd0, 4'd0, 5, 0);

        // both masters requesting: alternation starts at master0 after reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rr = 0;
        for (int i = 0; i < 4; i++)
            do_txn(2'b11, 32'h0000_0100, 32'h0000_0200, 4'd0, 4'd0, 0, 0);

        // unmapped address: DECERR beats, first beat stalled 3 cycles
        do_txn(2'b01, 32'h0002_0000, 32'h0, 4'd1, 4'd0, 0, 3);
        // R backpressure toggling on a len 3 burst
        do_txn(2'b01, 32'h0000_0040, 32'h0, 4'd3, 4'd0, 0, 1);

        // reset in the middle of a len 7 burst
        clear_inputs();
        in_ar_valid = 2'b01;
        in_ar_addr  = {32'h0, 32'h0000_0080};
        in_ar_len   = {4'd0, 4'd7};
        tick();
        out_ar_ready = 2'b01;
        tick();
        in_ar_valid  = '0;
        out_ar_ready = '0;
        out_r_valid  = 2'b01;
        in_r_ready   = 2'b01;
        out_r_data   = 64'h0000_0000_1234_5678;
        tick();
        tick();
        chk("mid_burst_valid", 64'(in_r_valid), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check_quiet("mid_reset");
        chk("mid_reset_ar_addr", 64'(out_ar_addr), 64'd0);
        clear_inputs();
        rr = 0;
        do_txn(2'b10, 32'h0, 32'h0001_0008, 4'd0, 4'd2, 1, 0);

        // randomized traffic
        for (int it = 0; it < 24; it++) begin
            logic [31:0] ra[2];
            logic [3:0]  rl[2];
            for (int j = 0; j < 2; j++) begin
                int region;
                region = $urandom_range(0, 2);
                if (region == 2) ra[j] = {16'($urandom_range(2, 16'hFFFF)), 16'($urandom)};
                else             ra[j] = {16'(region), 16'($urandom)};
                rl[j] = 4'($urandom_range(0, 3));
            end
            do_txn(2'($urandom_range(1, 3)), ra[0], ra[1], rl[0], rl[1],
                   $urandom_range(0, 2), 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
